// File: rtl/conv3x3_mac_stride_1.sv
// -----------------------------------------------------------------------------
// conv3x3_mac_stride_1
//
// Pipelined 3x3 fixed-point convolution engine fed by a stride-1 line buffer.
// Each accepted nine-tap window is multiplied by a runtime-loaded kernel.
// A bias is then added and ReLU is applied optionally. The result is
// floor-shifted back to the shared Q format and saturated.
//
// Parameters
//   data_width : width of taps, weights, bias and result (signed)
//   frac_bits  : fractional bits of the shared Q format
//   relu_en    : 1 = clamp negative results to zero
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   weight_valid/weight_in: serial coefficient load (w0..w8, then bias)
//   weights_ready         : full kernel + bias loaded; windows accepted
//   window_valid          : window taps valid this cycle
//   window_0..window_8    : taps, window_0 oldest (top-left), window_8 newest
//   result_valid/result   : one strobe per accepted window, 4 edges later
// -----------------------------------------------------------------------------
module conv3x3_mac_stride_1 #(
   parameter int data_width = 16,
   parameter int frac_bits  = 8,
   parameter bit relu_en    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  weight_valid,
   input  logic [data_width-1:0] weight_in,
   output logic                  weights_ready,
   input  logic                  window_valid,
   input  logic [data_width-1:0] window_0,
   input  logic [data_width-1:0] window_1,
   input  logic [data_width-1:0] window_2,
   input  logic [data_width-1:0] window_3,
   input  logic [data_width-1:0] window_4,
   input  logic [data_width-1:0] window_5,
   input  logic [data_width-1:0] window_6,
   input  logic [data_width-1:0] window_7,
   input  logic [data_width-1:0] window_8,
   output logic                  result_valid,
   output logic [data_width-1:0] result
);

   localparam int prod_w = 2*data_width;
   localparam int row_w  = 2*data_width + 2;
   localparam int acc_w  = 2*data_width + 4;

   localparam logic signed [acc_w-1:0] sat_max =
      {{(acc_w-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
   localparam logic signed [acc_w-1:0] sat_min =
      {{(acc_w-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

   logic signed [data_width-1:0] coef [0:8];
   logic signed [data_width-1:0] bias;
   logic [3:0]                   load_cnt;
   logic                         accept;
   logic signed [data_width-1:0] taps [0:8];

   logic signed [prod_w-1:0]     prod_p1 [0:8];
   logic signed [data_width-1:0] bias_p1;
   logic signed [row_w-1:0]      row_p2 [0:2];
   logic signed [data_width-1:0] bias_p2;
   logic signed [acc_w-1:0]      acc_p3;
   logic                         vld_p1, vld_p2, vld_p3;

   assign taps[0] = window_0;
   assign taps[1] = window_1;
   assign taps[2] = window_2;
   assign taps[3] = window_3;
   assign taps[4] = window_4;
   assign taps[5] = window_5;
   assign taps[6] = window_6;
   assign taps[7] = window_7;
   assign taps[8] = window_8;

   // Acceptance uses the registered weights_ready, so a window presented in
   // the same cycle as a reload word still sees the old (complete) kernel.
   assign accept = window_valid & weights_ready;

   // Floor shift back to Q format, then optional ReLU.
   function automatic logic signed [acc_w-1:0] scale_relu(
      input logic signed [acc_w-1:0] acc);
      logic signed [acc_w-1:0] shifted;
      shifted = acc >>> frac_bits;
      if (relu_en && shifted[acc_w-1])
         shifted = '0;
      return shifted;
   endfunction

   function automatic logic [data_width-1:0] saturate(
      input logic signed [acc_w-1:0] val);
      logic signed [acc_w-1:0] clipped;
      if (val > sat_max)
         clipped = sat_max;
      else if (val < sat_min)
         clipped = sat_min;
      else
         clipped = val;
      return clipped[data_width-1:0];
   endfunction

   // Serial coefficient loader. A word arriving while the kernel is complete
   // always restarts the load at coef[0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 9; k++)
            coef[k] <= '0;
         bias          <= '0;
         load_cnt      <= '0;
         weights_ready <= 1'b0;
      end else if (weight_valid) begin
         if (weights_ready) begin
            coef[0]       <= weight_in;
            load_cnt      <= 4'd1;
            weights_ready <= 1'b0;
         end else if (load_cnt == 4'd9) begin
            bias          <= weight_in;
            load_cnt      <= '0;
            weights_ready <= 1'b1;
         end else begin
            coef[load_cnt] <= weight_in;
            load_cnt       <= load_cnt + 4'd1;
         end
      end
   end

   // Valid pipe and output register: cleared by reset so in-flight windows
   // never emit a strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1       <= 1'b0;
         vld_p2       <= 1'b0;
         vld_p3       <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
      end else begin
         vld_p1       <= accept;
         vld_p2       <= vld_p1;
         vld_p3       <= vld_p2;
         result_valid <= vld_p3;
         if (vld_p3)
            result <= saturate(scale_relu(acc_p3));
      end
   end

   // Data pipe (no reset needed; qualified by the valid pipe).
   always_ff @(posedge clk) begin
      // ---- S1: per-tap products; bias travels with the window ----
      for (int k = 0; k < 9; k++)
         prod_p1[k] <= prod_w'(taps[k]) * prod_w'(coef[k]);
      bias_p1 <= bias;

      // ---- S2: row sums ----
      for (int r = 0; r < 3; r++)
         row_p2[r] <= row_w'(prod_p1[3*r]) + row_w'(prod_p1[3*r+1])
                    + row_w'(prod_p1[3*r+2]);
      bias_p2 <= bias_p1;

      // ---- S3: accumulate rows plus bias aligned to product scale ----
      acc_p3 <= acc_w'(row_p2[0]) + acc_w'(row_p2[1]) + acc_w'(row_p2[2])
              + (acc_w'(bias_p2) <<< frac_bits);
   end

endmodule
